// File: rtl/lsu_unit_pkg.sv
// ---------------------------------------------------------------------------
// lsu_unit_pkg
// Shared constants and types for the load/store unit:
//   - RISCV_WORD_WIDTH : data/address word width
//   - LSU_BE_WIDTH     : number of byte enables on the data bus
//   - LSU_B/H/W/BU/HU  : funct3 access type codes
//   - lsu_state_e      : FSM state encoding (IDLE/REQ/WAIT, 2 bits)
// ---------------------------------------------------------------------------
package lsu_unit_pkg;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int LSU_BE_WIDTH     = 4;

    // funct3 access types; the encoding is fixed by the ISA, so these are
    // plain constants compared against the raw 3-bit field.
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_unit_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the load/store unit.
// Ports:
//   type_i     funct3 access type
//   addr_lo_i  effective address bits [1:0]
//   we_i       1 = store, 0 = load
//   wdata_i    raw store data (rs2)
//   rdata_i    raw word returned by memory
//   be_o       byte enables for the access
//   wdata_o    store data replicated across the byte lanes
//   illegal_o  access is misaligned or uses an unsupported type
//   rdata_o    load data shifted down and sign/zero-extended
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_unit_pkg::*;
(
    input  logic [2:0]                  type_i,
    input  logic [1:0]                  addr_lo_i,
    input  logic                        we_i,
    input  logic [RISCV_WORD_WIDTH-1:0] wdata_i,
    input  logic [RISCV_WORD_WIDTH-1:0] rdata_i,
    output logic [LSU_BE_WIDTH-1:0]     be_o,
    output logic [RISCV_WORD_WIDTH-1:0] wdata_o,
    output logic                        illegal_o,
    output logic [RISCV_WORD_WIDTH-1:0] rdata_o
);

    logic [RISCV_WORD_WIDTH-1:0] rdata_shifted;

    // Move the addressed byte/halfword down to bit 0.
    assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o      = 4'b0000;
        wdata_o   = wdata_i;
        illegal_o = 1'b0;
        rdata_o   = rdata_shifted;

        case (type_i)
            LSU_B, LSU_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                if (type_i == LSU_B) begin
                    rdata_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
                end else begin
                    rdata_o = {24'h0, rdata_shifted[7:0]};
                end
                // Unsigned variants only exist for loads.
                if (we_i && (type_i == LSU_BU)) begin
                    illegal_o = 1'b1;
                end
            end
            LSU_H, LSU_HU: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                if (type_i == LSU_H) begin
                    rdata_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
                end else begin
                    rdata_o = {16'h0, rdata_shifted[15:0]};
                end
                if (addr_lo_i[0] || (we_i && (type_i == LSU_HU))) begin
                    illegal_o = 1'b1;
                end
            end
            LSU_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_shifted;
                if (addr_lo_i != 2'b00) begin
                    illegal_o = 1'b1;
                end
            end
            default: begin
                // 011, 110, 111 are not load/store widths.
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// ---------------------------------------------------------------------------
// lsu_unit
// Load/store unit between the execute-stage ALU and a req/gnt/rvalid data
// memory bus. One memory transaction per accepted request; misaligned or
// illegal requests are rejected with an error pulse and never reach memory.
//
// Handshake: lsu_req_i is sampled only while the unit is IDLE
// (lsu_busy_o low). Completion is a one-cycle lsu_rvalid_o pulse, failure a
// one-cycle lsu_err_o pulse; in either pulse cycle the unit is IDLE again and
// accepts a new request. On the memory side data_req_o stays high with
// address/we/be/wdata stable until data_gnt_i; data_rvalid_i counts only
// after a grant (WAIT state).
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   lsu_req_i/we_i/type_i      access request, direction and funct3 type
//   lsu_addr_i, lsu_wdata_i    effective address, store data
//   lsu_busy_o                 unit is not IDLE
//   lsu_rvalid_o, lsu_rdata_o  completion pulse and formatted load data
//   lsu_err_o                  illegal/misaligned/timeout pulse
//   data_*                     memory-side request/grant/response bus
// ---------------------------------------------------------------------------
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        lsu_req_i,
    input  logic                        lsu_we_i,
    input  logic [2:0]                  lsu_type_i,
    input  logic [RISCV_WORD_WIDTH-1:0] lsu_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] lsu_wdata_i,
    output logic                        lsu_busy_o,
    output logic                        lsu_rvalid_o,
    output logic [RISCV_WORD_WIDTH-1:0] lsu_rdata_o,
    output logic                        lsu_err_o,
    output logic                        data_req_o,
    input  logic                        data_gnt_i,
    output logic [RISCV_WORD_WIDTH-1:0] data_addr_o,
    output logic                        data_we_o,
    output logic [LSU_BE_WIDTH-1:0]     data_be_o,
    output logic [RISCV_WORD_WIDTH-1:0] data_wdata_o,
    input  logic                        data_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] data_rdata_i
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // The deadline is checked on the last allowed cycle so that the abort
    // lands exactly TIMEOUT_CYCLES cycles after entering REQ.
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

    // FSM and transaction latches
    lsu_state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [2:0]                  type_q;
    logic [1:0]                  addr_lo_q;
    logic                        we_q;

    // Registered outputs
    logic                        busy_q;
    logic                        rvalid_q;
    logic [RISCV_WORD_WIDTH-1:0] rdata_q;
    logic                        err_q;
    logic                        req_q;
    logic [RISCV_WORD_WIDTH-1:0] addr_q;
    logic [LSU_BE_WIDTH-1:0]     be_q;
    logic [RISCV_WORD_WIDTH-1:0] wdata_q;

    // FSM decisions
    logic                        accept;
    logic                        reject;
    logic                        finish;
    logic                        abort;
    logic                        timeout_hit;

    // Alignment logic operands: live request fields while IDLE (decode of
    // a new request), latched fields otherwise (formatting the response).
    logic                        in_idle;
    logic [2:0]                  al_type;
    logic [1:0]                  al_addr_lo;
    logic                        al_we;
    logic [LSU_BE_WIDTH-1:0]     al_be;
    logic [RISCV_WORD_WIDTH-1:0] al_wdata;
    logic                        al_illegal;
    logic [RISCV_WORD_WIDTH-1:0] al_rdata;

    assign in_idle    = (state_q == LSU_IDLE);
    assign al_type    = in_idle ? lsu_type_i      : type_q;
    assign al_addr_lo = in_idle ? lsu_addr_i[1:0] : addr_lo_q;
    assign al_we      = in_idle ? lsu_we_i        : we_q;

    lsu_align u_align (
        .type_i    (al_type),
        .addr_lo_i (al_addr_lo),
        .we_i      (al_we),
        .wdata_i   (lsu_wdata_i),
        .rdata_i   (data_rdata_i),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .illegal_o (al_illegal),
        .rdata_o   (al_rdata)
    );

    assign timeout_hit = TIMEOUT_EN && (cnt_q >= TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        reject  = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i) begin
                    if (al_illegal) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A grant on the deadline cycle takes priority over abort.
                if (data_gnt_i) begin
                    state_d = LSU_WAIT;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
            LSU_WAIT: begin
                if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A response on the deadline cycle takes priority over abort.
                if (data_rvalid_i) begin
                    finish  = 1'b1;
                    state_d = LSU_IDLE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= LSU_IDLE;
            cnt_q     <= '0;
            type_q    <= 3'b000;
            addr_lo_q <= 2'b00;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != LSU_IDLE);
            req_q    <= (state_d == LSU_REQ);
            rvalid_q <= finish;
            err_q    <= reject | abort;
            // Stores complete with zero data.
            rdata_q  <= (finish && !we_q) ? al_rdata : '0;
            if (accept) begin
                type_q    <= lsu_type_i;
                addr_lo_q <= lsu_addr_i[1:0];
                we_q      <= lsu_we_i;
                addr_q    <= {lsu_addr_i[RISCV_WORD_WIDTH-1:2], 2'b00};
                be_q      <= al_be;
                wdata_q   <= al_wdata;
            end
        end
    end

    assign lsu_busy_o   = busy_q;
    assign lsu_rvalid_o = rvalid_q;
    assign lsu_rdata_o  = rdata_q;
    assign lsu_err_o    = err_q;
    assign data_req_o   = req_q;
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// ---------------------------------------------------------------------------
// tb_lsu_unit
// Directed bench for lsu_unit. Instance u_dut has the timeout disabled;
// u_to runs with TIMEOUT_CYCLES=4 and has its own req/gnt/rvalid lines.
// Inputs change and outputs are sampled at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lsu_unit;
    import lsu_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared request fields ----------------
    logic        lsu_we_i    = 1'b0;
    logic [2:0]  lsu_type_i  = 3'b000;
    logic [31:0] lsu_addr_i  = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic [31:0] data_rdata_i = '0;

    // ---------------- u_dut ----------------
    logic        lsu_req_i = 1'b0;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_req_o, data_we_o;
    logic [31:0] lsu_rdata_o, data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;

    // ---------------- u_to ----------------
    logic        to_req = 1'b0;
    logic        to_gnt = 1'b0;
    logic        to_rvalid_in = 1'b0;
    logic        to_busy, to_rvalid, to_err, to_data_req, to_data_we;
    logic [31:0] to_rdata, to_data_addr, to_data_wdata;
    logic [3:0]  to_data_be;

    lsu_unit u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_type_i    (lsu_type_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_busy_o    (lsu_busy_o),
        .lsu_rvalid_o  (lsu_rvalid_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_err_o     (lsu_err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    lsu_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) u_to (
        .clk_i         (clk),
        .rst_i         (rst),
        .lsu_req_i     (to_req),
        .lsu_we_i      (lsu_we_i),
        .lsu_type_i    (lsu_type_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_busy_o    (to_busy),
        .lsu_rvalid_o  (to_rvalid),
        .lsu_rdata_o   (to_rdata),
        .lsu_err_o     (to_err),
        .data_req_o    (to_data_req),
        .data_gnt_i    (to_gnt),
        .data_addr_o   (to_data_addr),
        .data_we_o     (to_data_we),
        .data_be_o     (to_data_be),
        .data_wdata_o  (to_data_wdata),
        .data_rvalid_i (to_rvalid_in),
        .data_rdata_i  (data_rdata_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- driver: one access on u_dut ----------------
    // Observations left here for the calling test to compare.
    int          r_req_cycles;
    int          r_done;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic        r_we, r_err;
    bit          r_stable;

    // Must be called at a falling edge; returns at the falling edge of the
    // cycle where lsu_rvalid_o/lsu_err_o is seen (or after a 20-cycle bound).
    task automatic run_access(input logic we, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gnt_delay, input logic [31:0] resp);
        bit sent;
        r_req_cycles = 0;
        r_done       = -1;
        r_stable     = 1'b1;
        r_err        = 1'b0;
        r_rdata      = 'x;
        r_addr       = 'x;
        r_wdata      = 'x;
        r_be         = 'x;
        r_we         = 1'bx;
        sent         = 1'b0;
        lsu_req_i    = 1'b1;
        lsu_we_i     = we;
        lsu_type_i   = typ;
        lsu_addr_i   = addr;
        lsu_wdata_i  = wdata;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            // Scramble request fields so any unlatched use shows up.
            lsu_req_i     = 1'b0;
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            lsu_addr_i    = 32'hFFFF_FFFF;
            lsu_wdata_i   = 32'h5555_5555;
            lsu_type_i    = 3'b111;
            lsu_we_i      = ~we;
            if (lsu_rvalid_o || lsu_err_o) begin
                r_done  = c;
                r_rdata = lsu_rdata_o;
                r_err   = lsu_err_o;
                break;
            end
            if (data_req_o) begin
                if (r_req_cycles == 0) begin
                    r_addr  = data_addr_o;
                    r_wdata = data_wdata_o;
                    r_be    = data_be_o;
                    r_we    = data_we_o;
                end else if (data_addr_o !== r_addr || data_wdata_o !== r_wdata ||
                             data_be_o !== r_be || data_we_o !== r_we) begin
                    r_stable = 1'b0;
                end
                r_req_cycles++;
                if (r_req_cycles > gnt_delay) data_gnt_i = 1'b1;
            end else if (r_req_cycles > 0 && !sent) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = resp;
                sent          = 1'b1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_req_o, data_we_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 00000",
                     {lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_req_o, data_we_o});
        end
        tests_run++;
        if ({lsu_rdata_o, data_addr_o, data_wdata_o, data_be_o} !== 100'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h be %b required all 0",
                     lsu_rdata_o, data_addr_o, data_wdata_o, data_be_o);
        end
        tests_run++;
        if ({to_busy, to_rvalid, to_err, to_data_req} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_to_flags: got %b required 0000",
                     {to_busy, to_rvalid, to_err, to_data_req});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        run_access(1'b0, LSU_W, 32'h0000_1000, 32'h0, 0, 32'hDEAD_BEEF);
        tests_run++;
        if (r_done !== 3) begin
            tests_failed++;
            $display("FAIL lw_latency: got %0d required 3", r_done);
        end
        tests_run++;
        if (r_addr !== 32'h0000_1000 || r_be !== 4'b1111 || r_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_bus: addr %h be %b we %b required 00001000 1111 0", r_addr, r_be, r_we);
        end
        tests_run++;
        if (r_req_cycles !== 1) begin
            tests_failed++;
            $display("FAIL lw_req_cycles: got %0d required 1", r_req_cycles);
        end
        tests_run++;
        if (r_rdata !== 32'hDEAD_BEEF || r_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_rdata: got %h err %b required deadbeef err 0", r_rdata, r_err);
        end
        tests_run++;
        if (lsu_busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_busy_at_done: got %b required 0", lsu_busy_o);
        end
        @(negedge clk);
        tests_run++;
        if (lsu_rvalid_o !== 1'b0 || lsu_rdata_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL lw_pulse_width: rvalid %b rdata %h required 0 0", lsu_rvalid_o, lsu_rdata_o);
        end
    endtask

    // Loads issued back to back: each new request goes in during the
    // completion cycle of the previous one.
    task automatic test_back_to_back_loads();
        logic [2:0]  typ  [6] = '{LSU_B, LSU_BU, LSU_B, LSU_H, LSU_HU, LSU_W};
        logic [31:0] addr [6] = '{32'h1003, 32'h1003, 32'h1001, 32'h1002, 32'h1002, 32'h1004};
        logic [31:0] resp [6] = '{32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC,
                                  32'h80AABBCC, 32'h80AABBCC, 32'h0123_4567};
        logic [3:0]  be   [6] = '{4'b1000, 4'b1000, 4'b0010, 4'b1100, 4'b1100, 4'b1111};
        logic [31:0] exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFBB,
                                  32'hFFFF_80AA, 32'h0000_80AA, 32'h0123_4567};
        logic [31:0] waddr [6] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
        for (int i = 0; i < 6; i++) begin
            run_access(1'b0, typ[i], addr[i], 32'h0, 0, resp[i]);
            tests_run++;
            if (r_done !== 3 || r_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_done[%0d]: done %0d err %b required 3 0", i, r_done, r_err);
            end
            tests_run++;
            if (r_be !== be[i] || r_addr !== waddr[i]) begin
                tests_failed++;
                $display("FAIL b2b_bus[%0d]: be %b addr %h required %b %h", i, r_be, r_addr, be[i], waddr[i]);
            end
            tests_run++;
            if (r_rdata !== exp[i]) begin
                tests_failed++;
                $display("FAIL b2b_rdata[%0d]: got %h required %h", i, r_rdata, exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stores();
        logic [2:0]  typ   [3] = '{LSU_H, LSU_B, LSU_W};
        logic [31:0] addr  [3] = '{32'h2002, 32'h3001, 32'h4004};
        logic [31:0] wd    [3] = '{32'h1234_ABCD, 32'h0000_00A5, 32'hCAFE_F00D};
        int          dly   [3] = '{3, 0, 1};
        logic [3:0]  be    [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ewd   [3] = '{32'hABCD_ABCD, 32'hA5A5_A5A5, 32'hCAFE_F00D};
        logic [31:0] eaddr [3] = '{32'h2000, 32'h3000, 32'h4004};
        for (int i = 0; i < 3; i++) begin
            run_access(1'b1, typ[i], addr[i], wd[i], dly[i], 32'hFFFF_FFFF);
            tests_run++;
            if (r_req_cycles !== dly[i] + 1 || r_stable !== 1'b1) begin
                tests_failed++;
                $display("FAIL st_hold[%0d]: req cycles %0d stable %b required %0d 1",
                         i, r_req_cycles, r_stable, dly[i] + 1);
            end
            tests_run++;
            if (r_be !== be[i] || r_wdata !== ewd[i] || r_addr !== eaddr[i] || r_we !== 1'b1) begin
                tests_failed++;
                $display("FAIL st_bus[%0d]: be %b wdata %h addr %h we %b required %b %h %h 1",
                         i, r_be, r_wdata, r_addr, r_we, be[i], ewd[i], eaddr[i]);
            end
            tests_run++;
            if (r_done !== dly[i] + 3 || r_rdata !== 32'h0 || r_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL st_done[%0d]: done %0d rdata %h err %b required %0d 00000000 0",
                         i, r_done, r_rdata, r_err, dly[i] + 3);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic        we   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  typ  [6] = '{LSU_W, 3'b011, LSU_BU, LSU_HU, LSU_H, 3'b110};
        logic [31:0] addr [6] = '{32'h1001, 32'h1000, 32'h1000, 32'h1000, 32'h1003, 32'h1000};
        for (int i = 0; i < 6; i++) begin
            lsu_req_i  = 1'b1;
            lsu_we_i   = we[i];
            lsu_type_i = typ[i];
            lsu_addr_i = addr[i];
            @(negedge clk);
            lsu_req_i = 1'b0;
            tests_run++;
            if (lsu_err_o !== 1'b1 || lsu_busy_o !== 1'b0 || data_req_o !== 1'b0 || lsu_rvalid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_pulse[%0d]: err %b busy %b req %b rvalid %b required 1 0 0 0",
                         i, lsu_err_o, lsu_busy_o, data_req_o, lsu_rvalid_o);
            end
            @(negedge clk);
            tests_run++;
            if (lsu_err_o !== 1'b0 || data_req_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_after[%0d]: err %b req %b busy %b required 0 0 0",
                         i, lsu_err_o, data_req_o, lsu_busy_o);
            end
        end
    endtask

    task automatic test_timeout();
        // No response: abort after 4 cycles in REQ/WAIT.
        to_req     = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_type_i = LSU_W;
        lsu_addr_i = 32'h5000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            to_req = 1'b0;
            to_gnt = (c == 1);
            tests_run++;
            if (to_err !== 1'b0 || to_busy !== 1'b1 || to_data_req !== (c == 1)) begin
                tests_failed++;
                $display("FAIL to_pending[%0d]: err %b busy %b req %b required 0 1 %b",
                         c, to_err, to_busy, to_data_req, (c == 1));
            end
        end
        @(negedge clk);
        to_gnt = 1'b0;
        tests_run++;
        if (to_err !== 1'b1 || to_busy !== 1'b0 || to_data_req !== 1'b0 || to_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_abort: err %b busy %b req %b rvalid %b required 1 0 0 0",
                     to_err, to_busy, to_data_req, to_rvalid);
        end
        @(negedge clk);
        to_rvalid_in = 1'b1;
        data_rdata_i = 32'h7777_7777;
        tests_run++;
        if (to_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_err_width: got %b required 0", to_err);
        end
        @(negedge clk);
        to_rvalid_in = 1'b0;
        tests_run++;
        if (to_rvalid !== 1'b0 || to_busy !== 1'b0 || to_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_stray_rvalid: rvalid %b busy %b err %b required 0 0 0",
                     to_rvalid, to_busy, to_err);
        end

        // Grant on the deadline cycle, then response: normal completion.
        to_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            to_req = 1'b0;
            to_gnt = (c == 4);
            tests_run++;
            if (to_data_req !== 1'b1) begin
                tests_failed++;
                $display("FAIL to_deadline_req[%0d]: got %b required 1", c, to_data_req);
            end
        end
        @(negedge clk);
        to_gnt       = 1'b0;
        to_rvalid_in = 1'b1;
        data_rdata_i = 32'h1122_3344;
        tests_run++;
        if (to_err !== 1'b0 || to_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL to_gnt_wins: err %b busy %b required 0 1", to_err, to_busy);
        end
        @(negedge clk);
        to_rvalid_in = 1'b0;
        tests_run++;
        if (to_rvalid !== 1'b1 || to_err !== 1'b0 || to_rdata !== 32'h1122_3344) begin
            tests_failed++;
            $display("FAIL to_rvalid_wins: rvalid %b err %b rdata %h required 1 0 11223344",
                     to_rvalid, to_err, to_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        // Reset while in REQ: data_req_o must drop without a clock edge.
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_type_i = LSU_W;
        lsu_addr_i = 32'h6000;
        @(negedge clk);
        lsu_req_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (data_req_o !== 1'b0 || lsu_busy_o !== 1'b0 || data_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_in_req: req %b busy %b addr %h required 0 0 00000000",
                     data_req_o, lsu_busy_o, data_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;

        // Reset while in WAIT.
        lsu_req_i  = 1'b1;
        lsu_addr_i = 32'h6004;
        @(negedge clk);
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        tests_run++;
        if (lsu_busy_o !== 1'b1 || data_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_pre_wait: busy %b req %b required 1 0", lsu_busy_o, data_req_o);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_req_o, data_we_o} !== 5'b0 ||
            data_addr_o !== 32'h0 || data_be_o !== 4'h0 || data_wdata_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_in_wait: flags %b addr %h be %b wdata %h required 00000 0 0 0",
                     {lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_req_o, data_we_o},
                     data_addr_o, data_be_o, data_wdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        // The lost transaction's response arrives late and must be ignored.
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h9999_9999;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        tests_run++;
        if (lsu_rvalid_o !== 1'b0 || lsu_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_stale_rvalid: rvalid %b err %b required 0 0", lsu_rvalid_o, lsu_err_o);
        end
        run_access(1'b0, LSU_W, 32'h0000_1000, 32'h0, 0, 32'h0BAD_F00D);
        tests_run++;
        if (r_done !== 3 || r_rdata !== 32'h0BAD_F00D || r_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_then_lw: done %0d rdata %h err %b required 3 0badf00d 0",
                     r_done, r_rdata, r_err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_back_to_back_loads();
        test_stores();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU sum as the effective address and rs2 as store data.
- Performs one data-memory transaction per request over a req/gnt/rvalid bus, then returns the aligned, sign- or zero-extended load data (or a store acknowledge) to writeback.
- Misaligned or illegal accesses are rejected without touching memory.

Parameters:
- TIMEOUT_CYCLES, 0, cycles allowed in REQ+WAIT before abort with error; 0 disables the timeout counter.
- CNT_WIDTH, 8, width of the timeout counter; TIMEOUT_CYCLES must be < 2^CNT_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- lsu_req_i  in  1  execute requests an access; sampled only in IDLE
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_type_i  in  3  funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr_i  in  32  effective address (ALU result)
- lsu_wdata_i  in  32  store data (rs2)
- lsu_busy_o  out  1  high whenever state != IDLE
- lsu_rvalid_o  out  1  one-cycle pulse: access completed
- lsu_rdata_o  out  32  formatted load data; 0 for stores; valid with lsu_rvalid_o
- lsu_err_o  out  1  one-cycle pulse: misaligned, illegal type, or timeout
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory accepted request
- data_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-replicated store data
- data_rvalid_i  in  1  response valid (loads and stores)
- data_rdata_i  in  32  response data

Behaviour:
- States: IDLE, REQ, WAIT.
- All outputs are registered.
- Reset value of every output is 0; the state resets to IDLE.
- IDLE, lsu_req_i=1 with a legal, aligned access:
  - latch addr, we, type, be and replicated wdata;
  - go to REQ.
- IDLE, lsu_req_i=1 with an illegal access:
  - illegal means a store with type 100/101, any type 011/11x, H/HU with addr[0]=1, or W with addr[1:0]!=00;
  - pulse lsu_err_o the next cycle, stay in IDLE, issue no memory request.
- REQ:
  - data_req_o=1; data_addr/we/be/wdata held stable until data_gnt_i;
  - on gnt go to WAIT and drop data_req_o the next cycle.
- WAIT:
  - on data_rvalid_i, register the formatted data, pulse lsu_rvalid_o for one cycle, return to IDLE.
- Minimum latency: lsu_req_i at cycle 0; data_req_o at 1; gnt at 1; rvalid at 2; lsu_rvalid_o at 3.
- lsu_busy_o is high from cycle 1 until the cycle lsu_rvalid_o or lsu_err_o is high. The requester must not assert lsu_req_i while busy; requests while busy are ignored.
- A new request is accepted in the same cycle lsu_rvalid_o is high (state is IDLE then).
- Byte enables:
  - B: 0001<<addr[1:0];
  - H: addr[1] ? 1100 : 0011;
  - W: 1111.
- Store data:
  - SB: {4{wdata[7:0]}};
  - SH: {2{wdata[15:0]}};
  - SW: wdata.
- Load data:
  - shift data_rdata_i right by 8*addr[1:0];
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W pass through.
- Stores: lsu_rdata_o=0 with the rvalid pulse.
- data_rvalid_i outside WAIT is ignored (stale response after reset or abort).
- Timeout (TIMEOUT_CYCLES>0):
  - the counter clears on entry to REQ and increments each cycle in REQ/WAIT;
  - when it reaches TIMEOUT_CYCLES: drop data_req_o, pulse lsu_err_o, go to IDLE.
  - gnt/rvalid arriving in the same cycle as the timeout wins: normal completion, no error.
- rst_i asserted mid-transaction: state goes to IDLE and data_req_o drops immediately (asynchronously). The transaction is lost and no pulse is produced.

Decomposition:
- lsu_defines.v holds:
  - LSU type codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - state encodings (LSU_IDLE/REQ/WAIT, 2 bits);
  - LSU_BE_WIDTH=4.
- Word width comes from RISCV_WORD_WIDTH in riscv_defines.v.
- Sub-module lsu_align (combinational): from type and addr[1:0], produce be, replicated wdata, the misalign/illegal flag, and formatted rdata.
- lsu_unit keeps the FSM, the latches and the timeout counter.

Test Plan:
- LW addr 0x1000, gnt same cycle, rvalid next with rdata 0xDEADBEEF -> data_addr 0x1000, be 1111, lsu_rvalid_o at cycle 3, lsu_rdata_o 0xDEADBEEF.
- LB addr 0x1003 and LBU addr 0x1003, rdata 0x80AABBCC -> be 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH addr 0x2002 wdata 0x1234ABCD, gnt delayed 3 cycles -> data_req_o held 4 cycles, be 1100, wdata 0xABCDABCD, inputs stable; rvalid gives lsu_rdata_o 0.
- LW addr 0x1001, and type 011 -> lsu_err_o pulse the next cycle, data_req_o never asserts, busy stays 0.
- TIMEOUT_CYCLES=4, gnt given, rvalid never -> lsu_err_o after 4 cycles in REQ/WAIT, IDLE; a later stray rvalid is ignored.
- rst_i pulsed while in WAIT -> all outputs 0 immediately; a following LW completes normally.
